// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared encodings for the multiply/divide unit and the controller that drives
// it: start codes, multdivOP operation codes, FSM states and the default busy
// cycle counts.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

    // start input: which class of long-latency operation to launch (11 unused)
    typedef enum logic [1:0] {
        START_NONE = 2'b00,
        START_MULT = 2'b01,
        START_DIV  = 2'b10
    } start_e;

    // multdivOP input: exact operation within the class
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// -----------------------------------------------------------------------------
// mdu_divider
// Combinational 32-bit divider, signed or unsigned. Signed division works on
// magnitudes: the quotient is negated when operand signs differ (truncation
// toward zero) and the remainder takes the sign of the dividend.
// A zero divisor raises div_by_zero; quotient/remainder are then meaningless
// and the caller must not commit them.
//
// The whole module exists only when MDU_DIV_EN is defined, so a build without
// division carries no divider at all.
//
// Ports:
//   dividend    in  32  numerator (rs)
//   divisor     in  32  denominator (rt)
//   is_signed   in  1   1 = div, 0 = divu
//   quotient    out 32  LO result
//   remainder   out 32  HI result
//   div_by_zero out 1   divisor == 0
// -----------------------------------------------------------------------------
`ifdef MDU_DIV_EN
module mdu_divider (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign neg_a = is_signed & dividend[31];
    assign neg_b = is_signed & divisor[31];

    assign mag_a = neg_a ? (32'd0 - dividend) : dividend;
    assign mag_b = neg_b ? (32'd0 - divisor)  : divisor;

    assign div_by_zero = (divisor == 32'd0);

    // Keep the operator away from a zero divisor so simulation never sees X.
    assign safe_b = div_by_zero ? 32'd1 : mag_b;

    assign q_mag = mag_a / safe_b;
    assign r_mag = mag_a % safe_b;

    assign quotient  = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    assign remainder = neg_a ? (32'd0 - r_mag) : r_mag;

endmodule
`endif

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle multiply/divide unit with HI/LO registers (MIPS style).
// A start in IDLE latches operands and operation, then the unit stays BUSY for
// MULT_CYCLES or DIV_CYCLES cycles and commits the result to HI/LO on the edge
// that ends the last busy cycle. mthi/mtlo write A directly while idle.
//
// Build option: MDU_DIV_EN -- when defined, div/divu are supported through the
// mdu_divider sub-module; when undefined, start = 10 is a no-op and no divider
// is built.
//
// Ports:
//   clk        in  1   rising-edge clock
//   reset      in  1   asynchronous, active-high reset
//   start      in  2   01 mult class, 10 div class, 00 none, 11 no-op
//   multdivOP  in  2   00 mult, 01 multu, 10 div, 11 divu
//   HIWrite    in  1   mthi: HI <= A (idle, start = 00 only)
//   LOWrite    in  1   mtlo: LO <= A (idle, start = 00 only)
//   HILOOP     in  1   read select: 1 = HI, 0 = LO
//   A          in  32  rs operand / mthi-mtlo data
//   B          in  32  rt operand
//   busy       out 1   operation in flight
//   HILO_out   out 32  selected HI or LO register (no write forwarding)
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  start,
    input  logic [1:0]  multdivOP,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic        HILOOP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HILO_out
);

    localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

    state_e           state;
    state_e           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    op_e              op_q;
    op_e              op_next;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi;
    logic [31:0]      lo;

    logic             accept;
    logic             finish;
    logic             hi_we;
    logic             lo_we;

    // ------------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        next_state = state;
        count_next = count;
        op_next    = op_q;
        accept     = 1'b0;
        finish     = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start == START_MULT) begin
                    accept     = 1'b1;
                    op_next    = (multdivOP == OP_MULT) ? OP_MULT : OP_MULTU;
                    count_next = CNT_W'(MULT_CYCLES);
                    next_state = ST_BUSY;
                end
`ifdef MDU_DIV_EN
                else if (start == START_DIV) begin
                    accept     = 1'b1;
                    op_next    = (multdivOP == OP_DIV) ? OP_DIV : OP_DIVU;
                    count_next = CNT_W'(DIV_CYCLES);
                    next_state = ST_BUSY;
                end
`endif
                // Any nonzero start (including 11, or 10 without a divider)
                // takes precedence and drops a same-cycle mthi/mtlo.
                else if (start == START_NONE) begin
                    hi_we = HIWrite;
                    lo_we = LOWrite;
                end
            end

            ST_BUSY: begin
                // start/HIWrite/LOWrite are ignored here; the hazard unit
                // stalls the pipeline while busy.
                count_next = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    finish     = 1'b1;
                    next_state = ST_IDLE;
                end
            end

            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= count_next;
        end
    end

    // ------------------------------------------------------------------------
    // Multiplier (inline): extend both operands to 64 bits; the low 64 bits of
    // the product are correct for both signed and unsigned operation.
    // ------------------------------------------------------------------------
    logic        mult_signed;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;

    assign mult_signed = (op_q == OP_MULT);
    assign a_ext       = {{32{mult_signed & a_q[31]}}, a_q};
    assign b_ext       = {{32{mult_signed & b_q[31]}}, b_q};
    assign product     = a_ext * b_ext;

`ifdef MDU_DIV_EN
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_zero;

    mdu_divider u_divider (
        .dividend    (a_q),
        .divisor     (b_q),
        .is_signed   (op_q == OP_DIV),
        .quotient    (div_quo),
        .remainder   (div_rem),
        .div_by_zero (div_zero)
    );
`endif

    // ------------------------------------------------------------------------
    // Operand latches and HI/LO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= OP_MULT;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            if (accept) begin
                op_q <= op_next;
                a_q  <= A;
                b_q  <= B;
            end

            if (finish) begin
                if (op_q == OP_MULT || op_q == OP_MULTU) begin
                    {hi, lo} <= product;
                end
`ifdef MDU_DIV_EN
                // A zero divisor leaves HI/LO untouched.
                else if (!div_zero) begin
                    hi <= div_rem;
                    lo <= div_quo;
                end
`endif
            end else begin
                if (hi_we) hi <= A;
                if (lo_we) lo <= A;
            end
        end
    end

    assign busy     = (state == ST_BUSY);
    assign HILO_out = HILOOP ? hi : lo;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  2  01 = mult/multu, 10 = div/divu, 00 = none; 11 illegal.
REQ-006 multdivOP  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-007 HIWrite  input  1  mthi: write A into HI.
REQ-008 LOWrite  input  1  mtlo: write A into LO.
REQ-009 HILOOP  input  1  read select: 1 = HI, 0 = LO.
REQ-010 A  input  32  rs operand (dividend / multiplicand / mthi-mtlo data).
REQ-011 B  input  32  rt operand (divisor / multiplier).
REQ-012 busy  output  1  operation in flight.
REQ-013 HILO_out  output  32  HI when HILOOP = 1, else LO; combinational.

Function
REQ-014 The unit SHALL implement a two-state FSM: IDLE and BUSY.
REQ-015 In IDLE, start = 01 or 10 SHALL latch A and B, latch the operation, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-016 For start sampled at edge T0, busy SHALL be high for exactly N cycles, T0+1 through T0+N.
REQ-017 HI/LO SHALL update on the edge ending cycle T0+N and be visible on HILO_out from cycle T0+N+1.
REQ-018 In BUSY, start, HIWrite and LOWrite SHALL be ignored. The hazard unit stalls on (start != 00 || busy).
REQ-019 start = 11 SHALL be a no-op.
REQ-020 mult SHALL produce {HI,LO} = signed 64-bit A*B. multu SHALL produce the unsigned 64-bit product.
REQ-021 div SHALL produce LO = signed quotient (truncated toward zero) and HI = remainder carrying the sign of the dividend.
REQ-022 divu SHALL produce LO = unsigned quotient and HI = unsigned remainder.
REQ-023 For a divisor of zero, HI and LO SHALL remain unchanged, while busy still runs for DIV_CYCLES.
REQ-024 In IDLE, HIWrite or LOWrite SHALL write A at the edge when start = 00. If start != 00 in the same cycle, start wins and the write is dropped.
REQ-025 HIWrite and LOWrite together SHALL write both registers.
REQ-026 HILO_out SHALL be a pure function of HILOOP and the registered HI/LO, with no forwarding of a same-cycle write.
REQ-027 Operands latched at start SHALL be used; A/B changes during BUSY SHALL NOT affect the result.

Reset
REQ-028 On reset, state = IDLE, counter = 0, busy = 0, HI = LO = 0, and latched operands = 0, taking effect immediately without waiting for clk.
REQ-029 Reset mid-operation SHALL abort the operation with no HI/LO update.

Configuration
REQ-030 Macro MDU_DIV_EN: when defined, div/divu SHALL be supported as specified.
REQ-031 When MDU_DIV_EN is undefined, no divider logic SHALL be synthesized and start = 10 SHALL behave as no-op with busy staying 0.

Structure
REQ-032 A shared package SHALL hold the start codes (00/01/10) and the multdivOP codes (00/01/10/11), matching the controller's encoding, plus the MULT_CYCLES and DIV_CYCLES defaults.
REQ-033 The divider datapath SHALL be a sub-module mdu_divider, combinational and 32-bit signed/unsigned, instantiated only under MDU_DIV_EN.
REQ-034 The multiplier SHALL stay inline.

Verification
REQ-035 mult: A = 0xFFFFFFFE (-2), B = 3, start = 01, op = 00 -> busy high 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
REQ-036 multu: same operands, op = 01 -> HI = 0x00000002, LO = 0xFFFFFFFA after 5 busy cycles.
REQ-037 div: A = -7 (0xFFFFFFF9), B = 2, op = 10 -> busy 10 cycles; then LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). divu with A = 7, B = 2 -> LO = 3, HI = 1.
REQ-038 Divide by zero: mthi 0x1234, mtlo 0x5678, then div with B = 0 -> busy 10 cycles; then HI = 0x1234, LO = 0x5678.
REQ-039 Ignore during BUSY: during BUSY, assert HIWrite with A = 0xDEAD and a second start -> both ignored, and the original result lands at T0+N. Reset asserted in cycle T0+3 -> busy = 0, HI = LO = 0 immediately.
REQ-040 Macro off: with MDU_DIV_EN undefined, start = 10 -> busy stays 0 and HI/LO unchanged.
